icap_reboot_seq: RTL
====================

Name: icap_reboot_seq

Overview:
- Controller in front of the Wishbone-attached 8-bit ICAP port (Virtex-6 ICAP, x8 mode).
- Shares the port between two users:
  - a software Wishbone pass-through, used for raw ICAP access;
  - an internal sequencer that issues the warm-boot (IPROG) command stream with a selectable WBSTAR address.
- Used for firmware-triggered reload of an alternate bitstream image from flash.

Parameters:
- NOOP_CNT, 2: number of trailing NOOP words (32'h20000000) after IPROG; legal range 1..15.
- SYNC_DUMMY, 32'hFFFFFFFF: dummy/pad word sent first.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_stb  in  1  one-cycle pulse; starts a reboot sequence
- cfg_addr  in  32  WBSTAR value; latched on accepted cfg_stb
- busy  out  1  high from sequence acceptance until completion
- done  out  1  sticky; set when the last sequence byte is acked
- s_cyc, s_stb, s_we  in  1 each  software Wishbone slave side
- s_dat_i  in  8  software write data
- s_dat_o  out  8  software read data (m_dat_i forwarded)
- s_ack  out  1  software ack
- m_cyc, m_stb, m_we  out  1 each  master side to the ICAP slave
- m_dat_o  out  8  byte to ICAP
- m_dat_i  in  8  ICAP read byte
- m_ack  in  1  ICAP slave ack; arrives 2 cycles after m_stb is sampled

Behaviour:

Reset values:
- busy=0, done=0, s_ack=0.
- m_cyc=0, m_stb=0, m_we=0, m_dat_o=0.
- Internal state=IDLE, word index=0, byte index=0.

State machine:
- IDLE:
  - cfg_stb=1 → latch cfg_addr, busy=1, go to SEQ_REQ.
  - Else if s_cyc&s_stb → go to PASS.
  - cfg_stb wins when both arrive in the same cycle; the software request stalls (s_ack stays 0) until the sequence ends.
- PASS:
  - m_cyc/m_stb/m_we/m_dat_o driven combinationally from s_cyc/s_stb/s_we/s_dat_i.
  - s_ack=m_ack; s_dat_o=m_dat_i.
  - On m_ack → IDLE (next cycle).
  - cfg_stb during PASS is ignored; no queueing.
- SEQ_REQ:
  - Registered outputs: m_cyc=1, m_stb=1, m_we=1, m_dat_o=current byte.
  - Hold until m_ack. On m_ack → SEQ_GAP, m_stb=0 from the next cycle.
- SEQ_GAP:
  - One idle cycle with m_stb=0, which guarantees the slave returns to idle.
  - If more bytes remain → advance index, go to SEQ_REQ.
  - If the last byte is done → done=1, busy=0, m_cyc=0, go to IDLE.
- Byte period is exactly 4 cycles: stb, stb, stb+ack, gap.

Command stream:
- 32-bit words, each sent MSB byte first:
  - SYNC_DUMMY
  - 32'hAA995566
  - 32'h20000000
  - 32'h30020001
  - latched cfg_addr
  - 32'h30008001
  - 32'h0000000F
  - then NOOP_CNT × 32'h20000000
- Total bytes = 4×(7+NOOP_CNT); 36 at the default.
- Word index wraps to 0 after the last word.

Boundary conditions:
- cfg_stb while busy: ignored; latched address is unchanged.
- s_stb while busy: s_ack=0, m_* stays owned by the sequencer.
- cfg_stb after done: a new sequence runs; done is cleared on acceptance.
- Reset mid-operation: all outputs return to reset values at the next edge. A partial stream is abandoned; no recovery beyond that.
- Software reads in PASS: m_we=0, data is returned in the ack cycle.

Optional Feature:
- Macro: ICAP_BITSWAP_EN.
- Defined: every sequencer byte is bit-reversed within the byte (bit0↔bit7, etc.) before driving m_dat_o, as the Virtex-6 x8 ICAP expects. Example: 8'hAA stays 8'h55?
  - Correction: 8'hAA becomes 8'h55 and 8'h99 becomes 8'h99.
  - PASS data is never swapped.
- Undefined: bytes are sent unmodified; software must pre-swap its own data.

Test Plan:
- Basic sequence: reset, then cfg_stb with cfg_addr=32'h00340000, macro off.
  - Exactly 36 m_stb rising edges.
  - Byte stream FF FF FF FF AA 99 55 66 20 00 00 00 30 02 00 01 00 34 00 00 30 00 80 01 00 00 00 0F, then 2×(20 00 00 00).
  - done=1 and busy=0 at cycle 1+36×4 after cfg_stb (±1).
- Bitswap: with ICAP_BITSWAP_EN, the same run yields bytes FF FF FF FF 55 99 AA 66 04 00… (per-byte bit reversal).
- Pass-through: s_we=1, s_dat_i=8'h5A → m_dat_o=8'h5A with m_we=1; s_ack high exactly in the m_ack cycle; state returns to IDLE.
- Contention:
  - cfg_stb and s_stb in the same cycle → the sequence runs first, with no s_ack during it; the software write completes after done.
  - cfg_stb during PASS → ignored, busy stays 0.
- Reset mid-stream: assert reset after byte 10 → next cycle m_cyc=0, m_stb=0, busy=0, done=0; a fresh cfg_stb restarts from byte 0 (FF).
- Re-trigger while busy: second cfg_stb with addr 32'h12345678 mid-sequence → ignored; the stream still carries the first address, and exactly 36 bytes are sent.

Source files
------------

// File: rtl/icap_reboot_seq.sv
// icap_reboot_seq: shares an 8-bit Wishbone ICAP port between software pass-through and an IPROG warm-boot sequencer.
// Optional macro ICAP_BITSWAP_EN bit-reverses every sequencer byte (x8 ICAP bit order); pass-through data is never swapped.
module icap_reboot_seq #(
  parameter int          NOOP_CNT   = 2,
  parameter logic [31:0] SYNC_DUMMY = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_stb,
  input  logic [31:0] cfg_addr,
  output logic        busy,
  output logic        done,
  input  logic        s_cyc,
  input  logic        s_stb,
  input  logic        s_we,
  input  logic [7:0]  s_dat_i,
  output logic [7:0]  s_dat_o,
  output logic        s_ack,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [7:0]  m_dat_o,
  input  logic [7:0]  m_dat_i,
  input  logic        m_ack
);
  typedef enum logic [1:0] {IDLE, PASS, SEQ_REQ, SEQ_GAP} state_t;
  localparam logic [4:0] LAST_W = 5'(6 + NOOP_CNT);
  state_t      r_state, w_next;
  logic [31:0] r_addr, w_word;
  logic [4:0]  r_widx;
  logic [1:0]  r_bidx;
  logic        r_done;
  logic [7:0]  w_raw, w_byte;
  logic        w_seq, w_pass, w_accept, w_last;
  assign w_seq    = (r_state == SEQ_REQ) || (r_state == SEQ_GAP);
  assign w_pass   = r_state == PASS;
  assign w_accept = (r_state == IDLE) && cfg_stb;
  assign w_last   = (r_widx == LAST_W) && (r_bidx == 2'd3);
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = cfg_stb ? SEQ_REQ : (s_cyc && s_stb) ? PASS : IDLE;
      PASS:    w_next = m_ack ? IDLE : PASS;
      SEQ_REQ: w_next = m_ack ? SEQ_GAP : SEQ_REQ;
      default: w_next = w_last ? IDLE : SEQ_REQ;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_addr <= '0;
      r_widx <= '0;
      r_bidx <= '0;
      r_done <= 1'b0;
    end else if (w_accept) begin
      r_addr <= cfg_addr;
      r_widx <= '0;
      r_bidx <= '0;
      r_done <= 1'b0;
    end else if (r_state == SEQ_GAP) begin
      r_bidx <= r_bidx + 2'd1;
      r_widx <= (r_bidx != 2'd3) ? r_widx : w_last ? 5'd0 : r_widx + 5'd1;
      r_done <= r_done | w_last;
    end
  // Words 7.. are the trailing NOOPs
  always_comb begin
    w_word = r_widx == 5'd0 ? SYNC_DUMMY :
             r_widx == 5'd1 ? 32'hAA995566 :
             r_widx == 5'd2 ? 32'h20000000 :
             r_widx == 5'd3 ? 32'h30020001 :
             r_widx == 5'd4 ? r_addr :
             r_widx == 5'd5 ? 32'h30008001 :
             r_widx == 5'd6 ? 32'h0000000F : 32'h20000000;
    w_raw  = w_word[{~r_bidx, 3'b000} +: 8];
  end
`ifdef ICAP_BITSWAP_EN
  assign w_byte = {<<{w_raw}};
`else
  assign w_byte = w_raw;
`endif
  always_comb begin
    m_cyc   = w_pass ? s_cyc : w_seq;
    m_stb   = w_pass ? s_stb : (r_state == SEQ_REQ);
    m_we    = w_pass ? s_we : w_seq;
    m_dat_o = w_pass ? s_dat_i : w_seq ? w_byte : 8'h00;
    s_ack   = w_pass && m_ack;
    s_dat_o = w_pass ? m_dat_i : 8'h00;
    busy    = w_seq;
    done    = r_done;
  end
endmodule
